// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    // Run sequencing: host-only idle, shared run, response drain
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Requester identifiers, also used as the response id
    localparam logic ID_CORE = 1'b0;
    localparam logic ID_HOST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way combinational picker. Bit 0 = core, bit 1 = host.
//                On conflict, fair mode grants the side that did not win
//                last; fixed mode always grants the core.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       fair_i,
    output logic [1:0] gnt_o
);

    // One-hot (or zero) grant; a lone request always wins
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            if (fair_i && (last_i == ID_CORE)) begin
                gnt_o = 2'b10;
            end else begin
                gnt_o = 2'b01;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb
//  Description : Shares the single-port data memory between the core
//                load/store port and the host port, and sequences a run
//                (idle -> run -> drain -> idle with done raised).
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int FAIR = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic          core_done_i,
    input  logic          c_req_i,
    input  logic          c_we_i,
    input  logic [AW-1:0] c_addr_i,
    input  logic [DW-1:0] c_wdat_i,
    output logic          c_gnt_o,
    input  logic          h_req_i,
    input  logic          h_we_i,
    input  logic [AW-1:0] h_addr_i,
    input  logic [DW-1:0] h_wdat_i,
    output logic          h_gnt_o,
    output logic          rsp_valid_o,
    output logic          rsp_id_o,
    output logic [DW-1:0] rsp_rdat_o,
    output logic          mem_wr_en_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_dat_in_o,
    input  logic [DW-1:0] mem_dat_out_i,
    output logic          busy_o,
    output logic          done_o
);

    arb_state_t    state_q;
    logic          last_gnt_q;
    logic          done_q;
    logic          rsp_valid_q;
    logic          rsp_id_q;
    logic [DW-1:0] rsp_rdat_q;

    logic [1:0]    w_arb_gnt;
    logic          w_c_gnt;
    logic          w_h_gnt;
    logic          w_rd_fire;

    rr_arb2 u_rr_arb2 (
        .req_i  ({h_req_i, c_req_i}),
        .last_i (last_gnt_q),
        .fair_i (FAIR != 0),
        .gnt_o  (w_arb_gnt)
    );

    // Grant selection by phase: host only in IDLE, arbitrated in RUN, none in DRAIN
    always_comb begin
        w_c_gnt = 1'b0;
        w_h_gnt = 1'b0;
        case (state_q)
            IDLE:    w_h_gnt = h_req_i;
            RUN: begin
                w_c_gnt = w_arb_gnt[0];
                w_h_gnt = w_arb_gnt[1];
            end
            default: ;
        endcase
    end

    // Memory port mux; an idle port presents zeros so the bus is quiet
    always_comb begin
        mem_addr_o   = '0;
        mem_dat_in_o = '0;
        mem_wr_en_o  = 1'b0;
        if (w_c_gnt) begin
            mem_addr_o   = c_addr_i;
            mem_dat_in_o = c_wdat_i;
            mem_wr_en_o  = c_we_i;
        end else if (w_h_gnt) begin
            mem_addr_o   = h_addr_i;
            mem_dat_in_o = h_wdat_i;
            mem_wr_en_o  = h_we_i;
        end
    end

    assign w_rd_fire = (w_c_gnt & ~c_we_i) | (w_h_gnt & ~h_we_i);

    // Run sequencer, fairness memory and done flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_gnt_q <= ID_HOST;
            done_q     <= 1'b0;
        end else begin
            if ((state_q == RUN) && (w_c_gnt || w_h_gnt)) begin
                last_gnt_q <= w_h_gnt ? ID_HOST : ID_CORE;
            end
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= RUN;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (core_done_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read response: one-cycle pulse capturing data of a granted read
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= ID_CORE;
            rsp_rdat_q  <= '0;
        end else begin
            rsp_valid_q <= w_rd_fire;
            if (w_rd_fire) begin
                rsp_id_q   <= w_h_gnt ? ID_HOST : ID_CORE;
                rsp_rdat_q <= mem_dat_out_i;
            end
        end
    end

    assign c_gnt_o     = w_c_gnt;
    assign h_gnt_o     = w_h_gnt;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_rdat_o  = rsp_rdat_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arb
//  Description : Self-checking bench for dmem_arb. A fair instance and a
//                fixed-priority instance share stimulus; each has its own
//                256x8 memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, core_done;
    logic       c_req, c_we, h_req, h_we;
    logic [7:0] c_addr, c_wdat, h_addr, h_wdat;
    logic       mem_clr;

    logic       c_gnt0, h_gnt0, rv0, rid0, we0, busy0, done0;
    logic [7:0] rdat0, addr0, din0, dout0;
    logic       c_gnt1, h_gnt1, rv1, rid1, we1, busy1, done1;
    logic [7:0] rdat1, addr1, din1, dout1;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arb #(.AW(8), .DW(8), .FAIR(1)) u_fair (
        .clk(clk), .reset(reset), .start_i(start), .core_done_i(core_done),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdat_i(c_wdat), .c_gnt_o(c_gnt0),
        .h_req_i(h_req), .h_we_i(h_we), .h_addr_i(h_addr), .h_wdat_i(h_wdat), .h_gnt_o(h_gnt0),
        .rsp_valid_o(rv0), .rsp_id_o(rid0), .rsp_rdat_o(rdat0),
        .mem_wr_en_o(we0), .mem_addr_o(addr0), .mem_dat_in_o(din0), .mem_dat_out_i(dout0),
        .busy_o(busy0), .done_o(done0)
    );

    dmem_arb #(.AW(8), .DW(8), .FAIR(0)) u_fixed (
        .clk(clk), .reset(reset), .start_i(start), .core_done_i(core_done),
        .c_req_i(c_req), .c_we_i(c_we), .c_addr_i(c_addr), .c_wdat_i(c_wdat), .c_gnt_o(c_gnt1),
        .h_req_i(h_req), .h_we_i(h_we), .h_addr_i(h_addr), .h_wdat_i(h_wdat), .h_gnt_o(h_gnt1),
        .rsp_valid_o(rv1), .rsp_id_o(rid1), .rsp_rdat_o(rdat1),
        .mem_wr_en_o(we1), .mem_addr_o(addr1), .mem_dat_in_o(din1), .mem_dat_out_i(dout1),
        .busy_o(busy1), .done_o(done1)
    );

    // Memory models: combinational read, write on clock edge, bulk clear on demand
    assign dout0 = mem0[addr0];
    assign dout1 = mem1[addr1];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int k = 0; k < 256; k++) begin
                mem0[k] <= 8'h00;
                mem1[k] <= 8'h00;
            end
        end else begin
            if (we0) mem0[addr0] <= din0;
            if (we1) mem1[addr1] <= din1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       start, cdone;
        logic       creq, cwe; logic [7:0] caddr, cwdat;
        logic       hreq, hwe; logic [7:0] haddr, hwdat;
        logic       cg, hg, cg1, hg1;
        logic       rv, rid; logic [7:0] rdat;
        logic       busy, done;
    } vec_t;

    function automatic vec_t mk(
        input logic st, input logic cd,
        input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd8,
        input logic hr, input logic hw, input logic [7:0] ha, input logic [7:0] hd8,
        input logic cg, input logic hg, input logic cg1, input logic hg1,
        input logic rv, input logic rid, input logic [7:0] rdat,
        input logic bsy, input logic dn);
        vec_t v;
        v.start = st; v.cdone = cd;
        v.creq = cr; v.cwe = cw; v.caddr = ca; v.cwdat = cd8;
        v.hreq = hr; v.hwe = hw; v.haddr = ha; v.hwdat = hd8;
        v.cg = cg; v.hg = hg; v.cg1 = cg1; v.hg1 = hg1;
        v.rv = rv; v.rid = rid; v.rdat = rdat; v.busy = bsy; v.done = dn;
        return v;
    endfunction

    task automatic idle_inputs();
        start = 0; core_done = 0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdat = 0;
        h_req = 0; h_we = 0; h_addr = 0; h_wdat = 0;
    endtask

    task automatic do_reset();
        reset = 1; mem_clr = 1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        reset = 0; mem_clr = 0;
    endtask

    // Reference model state (fair and fixed instances share phase, differ in last winner)
    int         m_ph;          // 0 idle, 1 run, 2 drain
    logic       m_host_last0, m_host_last1;
    logic       m_done, m_rv, m_rid;
    logic [7:0] m_rdat;
    logic [7:0] ref_mem [256];

    // Expected grant pair {core, host} from the arbitration rules
    function automatic logic [1:0] exp_gnt(input int ph, input bit fair, input logic host_last,
                                           input logic cr, input logic hr);
        if (ph == 0) return {1'b0, hr};
        if (ph == 2) return 2'b00;
        if (cr && hr) begin
            if (!fair) return 2'b10;
            return host_last ? 2'b10 : 2'b01;
        end
        return {cr, hr};
    endfunction

    vec_t tv [18];

    initial begin
        // Directed sequence: idle host access, run start, fairness, drain, restart
        //        st cd  cr cw ca    cwd   hr hw ha    hwd    cg hg cg1 hg1 rv rid rdat  bsy dn
        tv[0]  = mk(0,0, 1,0,8'h30,8'h00, 1,1,8'h10,8'h5A, 0,1,0,1, 0,0,8'h00, 0,0);
        tv[1]  = mk(0,0, 0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,1,0,1, 0,0,8'h00, 0,0);
        tv[2]  = mk(1,0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 1,1,8'h5A, 0,0);
        tv[3]  = mk(0,0, 1,0,8'h10,8'h00, 0,0,8'h00,8'h00, 1,0,1,0, 0,0,8'h00, 1,0);
        tv[4]  = mk(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 1,0,8'h5A, 1,0);
        tv[5]  = mk(0,0, 0,0,8'h00,8'h00, 1,1,8'h20,8'h77, 0,1,0,1, 0,0,8'h00, 1,0);
        tv[6]  = mk(0,0, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,0,1,0, 0,0,8'h00, 1,0);
        tv[7]  = mk(0,0, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 0,1,1,0, 1,0,8'h5A, 1,0);
        tv[8]  = mk(0,0, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 1,0,1,0, 1,1,8'h77, 1,0);
        tv[9]  = mk(0,0, 1,0,8'h10,8'h00, 1,0,8'h20,8'h00, 0,1,1,0, 1,0,8'h5A, 1,0);
        tv[10] = mk(0,1, 1,0,8'h20,8'h00, 0,0,8'h00,8'h00, 1,0,1,0, 1,1,8'h77, 1,0);
        tv[11] = mk(0,0, 1,0,8'h10,8'h00, 1,0,8'h10,8'h00, 0,0,0,0, 1,0,8'h77, 1,0);
        tv[12] = mk(0,0, 0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,1,0,1, 0,0,8'h00, 0,1);
        tv[13] = mk(1,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 1,1,8'h5A, 0,1);
        tv[14] = mk(0,0, 0,0,8'h00,8'h00, 1,0,8'h20,8'h00, 0,1,0,1, 0,0,8'h00, 1,0);
        tv[15] = mk(0,1, 0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,1,0,1, 1,1,8'h77, 1,0);
        tv[16] = mk(0,0, 0,0,8'h00,8'h00, 1,0,8'h10,8'h00, 0,0,0,0, 1,1,8'h5A, 1,0);
        tv[17] = mk(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, 0,0,0,0, 0,0,8'h00, 0,1);

        do_reset();
        chk("reset rsp_valid", rv0, 0);
        chk("reset rsp_id",    rid0, 0);
        chk("reset rsp_rdat",  rdat0, 0);
        chk("reset busy",      busy0, 0);
        chk("reset done",      done0, 0);

        for (int i = 0; i < 18; i++) begin
            @(posedge clk); #1;
            chk($sformatf("v%0d rsp_valid", i), rv0, tv[i].rv);
            if (tv[i].rv) begin
                chk($sformatf("v%0d rsp_id", i),   rid0,  tv[i].rid);
                chk($sformatf("v%0d rsp_rdat", i), rdat0, tv[i].rdat);
            end
            chk($sformatf("v%0d busy", i), busy0, tv[i].busy);
            chk($sformatf("v%0d done", i), done0, tv[i].done);
            start = tv[i].start; core_done = tv[i].cdone;
            c_req = tv[i].creq; c_we = tv[i].cwe; c_addr = tv[i].caddr; c_wdat = tv[i].cwdat;
            h_req = tv[i].hreq; h_we = tv[i].hwe; h_addr = tv[i].haddr; h_wdat = tv[i].hwdat;
            #3;
            chk($sformatf("v%0d c_gnt fair", i),  c_gnt0, tv[i].cg);
            chk($sformatf("v%0d h_gnt fair", i),  h_gnt0, tv[i].hg);
            chk($sformatf("v%0d c_gnt fixed", i), c_gnt1, tv[i].cg1);
            chk($sformatf("v%0d h_gnt fixed", i), h_gnt1, tv[i].hg1);
        end
        chk("mem[0x10] host write", mem0[8'h10], 8'h5A);
        chk("mem[0x20] host write", mem0[8'h20], 8'h77);

        // Reset in the cycle after a read grant drops the run and its response
        @(posedge clk); #1; idle_inputs(); start = 1;
        @(posedge clk); #1; idle_inputs(); c_req = 1; c_addr = 8'h10;
        #3; chk("seq6 c_gnt", c_gnt0, 1);
        @(posedge clk); #1;
        chk("seq6 rsp before reset", rv0, 1);
        idle_inputs(); reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("seq6 rsp_valid", rv0, 0);
        chk("seq6 busy",      busy0, 0);
        chk("seq6 done",      done0, 0);

        // Randomized run against the reference model
        do_reset();
        for (int k = 0; k < 256; k++) ref_mem[k] = 8'h00;
        m_ph = 0; m_host_last0 = 1; m_host_last1 = 1;
        m_done = 0; m_rv = 0; m_rid = 0; m_rdat = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [1:0] g0, g1;
            logic       r_rst;
            @(posedge clk); #1;
            chk("rnd rsp_valid", rv0, m_rv);
            if (m_rv) begin
                chk("rnd rsp_id",   rid0,  m_rid);
                chk("rnd rsp_rdat", rdat0, m_rdat);
            end
            chk("rnd busy", busy0, (m_ph != 0));
            chk("rnd done", done0, m_done);
            chk("rnd busy fixed", busy1, (m_ph != 0));

            r_rst     = ($urandom_range(0, 199) == 0);
            reset     = r_rst;
            start     = ($urandom_range(0, 7) == 0);
            core_done = ($urandom_range(0, 11) == 0);
            c_req = $urandom_range(0, 1); c_we = $urandom_range(0, 1);
            c_addr = 8'($urandom_range(0, 15)); c_wdat = 8'($urandom);
            h_req = $urandom_range(0, 1); h_we = $urandom_range(0, 1);
            h_addr = 8'($urandom_range(0, 15)); h_wdat = 8'($urandom);
            #3;
            g0 = exp_gnt(m_ph, 1'b1, m_host_last0, c_req, h_req);
            g1 = exp_gnt(m_ph, 1'b0, m_host_last1, c_req, h_req);
            chk("rnd c_gnt fair",  c_gnt0, g0[1]);
            chk("rnd h_gnt fair",  h_gnt0, g0[0]);
            chk("rnd c_gnt fixed", c_gnt1, g1[1]);
            chk("rnd h_gnt fixed", h_gnt1, g1[0]);

            // Advance the model across the coming clock edge
            m_rv = 0;
            if (g0[1]) begin
                if (c_we) ref_mem[c_addr] = c_wdat;
                else begin m_rv = 1; m_rid = 0; m_rdat = ref_mem[c_addr]; end
            end else if (g0[0]) begin
                if (h_we) ref_mem[h_addr] = h_wdat;
                else begin m_rv = 1; m_rid = 1; m_rdat = ref_mem[h_addr]; end
            end
            if (m_ph == 1 && g0 != 2'b00) m_host_last0 = g0[0];
            if (m_ph == 1 && g1 != 2'b00) m_host_last1 = g1[0];
            case (m_ph)
                0: if (start) begin m_ph = 1; m_done = 0; end
                1: if (core_done) m_ph = 2;
                default: begin m_ph = 0; m_done = 1; end
            endcase
            if (r_rst) begin
                m_ph = 0; m_rv = 0; m_done = 0; m_rid = 0; m_rdat = 0;
                m_host_last0 = 1; m_host_last1 = 1;
            end
        end
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
